// File: rtl/uart_line_receiver.sv
// Line assembler behind uart_rx: collects bytes up to a CR/LF terminator with
// backspace editing, then hands the held line out over a valid/ready read port.
module uart_line_receiver #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned LEN_W   = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_valid,
   output logic             rx_data_ready,
   input  logic             flush,
   output logic             line_valid,
   output logic [LEN_W-1:0] line_len,
   output logic             line_overflow,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             rd_last,
   input  logic             rd_ready
);

   localparam int unsigned      ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
   localparam logic [7:0]       CH_CR   = 8'h0D;
   localparam logic [7:0]       CH_LF   = 8'h0A;
   localparam logic [7:0]       CH_BS   = 8'h08;
   localparam logic [7:0]       CH_DEL  = 8'h7F;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [LEN_W-1:0] count, count_d;
   logic [LEN_W-1:0] rd_ptr, rd_ptr_d;
   logic [LEN_W-1:0] len_d;
   logic             ovf, ovf_d;
   logic             lovf_d;
   logic             mem_we;
   logic             drain_d;
   logic [7:0]       rd_data_d;
   logic             rd_last_d;
   logic             rx_hs, rd_hs;
   logic             is_term, is_bs;

   logic [7:0] line_mem [MAX_LEN];

   assign rx_hs   = rx_data_valid & rx_data_ready;
   assign rd_hs   = rd_valid & rd_ready;
   assign is_term = (rx_data == CH_CR) || (rx_data == CH_LF);
   assign is_bs   = (rx_data == CH_BS) || (rx_data == CH_DEL);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_d;
      end
   end

   // Next-state, counters and next values of the registered line outputs
   always_comb begin
      state_d   = state;
      count_d   = count;
      rd_ptr_d  = rd_ptr;
      ovf_d     = ovf;
      len_d     = line_len;
      lovf_d    = line_overflow;
      mem_we    = 1'b0;
      drain_d   = 1'b0;
      rd_data_d = 8'h00;
      rd_last_d = 1'b0;

      if (flush) begin
         state_d  = FILL;
         count_d  = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         len_d    = '0;
         lovf_d   = 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               if (rx_hs) begin
                  if (is_term) begin
                     // Empty terminator swallows the LF of CR/LF and blank lines
                     if (count != '0) begin
                        state_d  = DRAIN;
                        len_d    = count;
                        lovf_d   = ovf;
                        rd_ptr_d = '0;
                     end
                  end else if (is_bs) begin
                     if (count != '0) begin
                        count_d = count - LEN_W'(1);
                     end
                  end else if (count < MAX_CNT) begin
                     mem_we  = 1'b1;
                     count_d = count + LEN_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (rd_hs) begin
                  if (rd_last) begin
                     state_d  = FILL;
                     count_d  = '0;
                     rd_ptr_d = '0;
                     ovf_d    = 1'b0;
                     len_d    = '0;
                     lovf_d   = 1'b0;
                  end else begin
                     rd_ptr_d = rd_ptr + LEN_W'(1);
                  end
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end

      // Read port is presented from the pointer value that will be held next cycle
      drain_d = (state_d == DRAIN);
      if (drain_d) begin
         rd_data_d = line_mem[rd_ptr_d[ADDR_W-1:0]];
         rd_last_d = (rd_ptr_d == (len_d - LEN_W'(1)));
      end
   end

   // Counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count         <= '0;
         rd_ptr        <= '0;
         ovf           <= 1'b0;
         line_len      <= '0;
         line_overflow <= 1'b0;
         rx_data_ready <= 1'b1;
         line_valid    <= 1'b0;
         rd_valid      <= 1'b0;
         rd_last       <= 1'b0;
         rd_data       <= 8'h00;
      end else begin
         count         <= count_d;
         rd_ptr        <= rd_ptr_d;
         ovf           <= ovf_d;
         line_len      <= len_d;
         line_overflow <= lovf_d;
         rx_data_ready <= ~drain_d;
         line_valid    <= drain_d;
         rd_valid      <= drain_d;
         rd_last       <= rd_last_d;
         rd_data       <= rd_data_d;
      end
   end

   // Line storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (mem_we) begin
         line_mem[count[ADDR_W-1:0]] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_line_receiver.sv
// Directed bench for uart_line_receiver: line assembly, editing, overflow,
// read back-pressure, flush and asynchronous reset.
module tb_uart_line_receiver;

   localparam int unsigned MAX_LEN = 64;
   localparam int unsigned LEN_W   = 7;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       rx_data;
   logic             rx_data_valid;
   logic             rx_data_ready;
   logic             flush;
   logic             line_valid;
   logic [LEN_W-1:0] line_len;
   logic             line_overflow;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_last;
   logic             rd_ready;

   int n_cmp = 0;
   int n_err = 0;

   uart_line_receiver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
      .flush(flush),
      .line_valid(line_valid), .line_len(line_len), .line_overflow(line_overflow),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data       = b;
      rx_data_valid = 1'b1;
      tick();
      rx_data_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0; flush = 1'b0; rd_ready = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({rx_data_ready, line_valid, line_len, line_overflow, rd_data, rd_valid, rd_last}
          !== {1'b1, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset: got rdy=%b lv=%b len=%0d ovf=%b d=%h v=%b l=%b, want rdy=1 rest 0",
                  rx_data_ready, line_valid, line_len, line_overflow, rd_data, rd_valid, rd_last);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
      n_cmp++;
      if (line_valid !== 1'b0) begin
         n_err++; $display("FAIL basic_pre_term: line_valid=%b want 0", line_valid);
      end
      send_byte(8'h0D);
      n_cmp++;
      if (line_valid !== 1'b1 || rd_valid !== 1'b1 || line_len !== 7'd3 || rx_data_ready !== 1'b0) begin
         n_err++;
         $display("FAIL basic_line: lv=%b v=%b len=%0d rdy=%b, want lv=1 v=1 len=3 rdy=0",
                  line_valid, rd_valid, line_len, rx_data_ready);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== exp[i] || rd_last !== (i == 2)) begin
            n_err++;
            $display("FAIL basic_rd[%0d]: v=%b d=%h l=%b, want v=1 d=%h l=%b",
                     i, rd_valid, rd_data, rd_last, exp[i], (i == 2));
         end
         rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      end
      n_cmp++;
      if (rx_data_ready !== 1'b1 || line_valid !== 1'b0 || rd_valid !== 1'b0 || line_len !== 7'd0) begin
         n_err++;
         $display("FAIL basic_done: rdy=%b lv=%b v=%b len=%0d, want rdy=1 lv=0 v=0 len=0",
                  rx_data_ready, line_valid, rd_valid, line_len);
      end
   endtask

   task automatic test_crlf();
      send_byte(8'h48); send_byte(8'h49); send_byte(8'h0D);
      n_cmp++;
      if (line_valid !== 1'b1 || line_len !== 7'd2) begin
         n_err++; $display("FAIL crlf_first: lv=%b len=%0d, want lv=1 len=2", line_valid, line_len);
      end
      for (int i = 0; i < 2; i++) begin
         rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      end
      send_byte(8'h0A);
      tick();
      n_cmp++;
      if (line_valid !== 1'b0 || rx_data_ready !== 1'b1) begin
         n_err++; $display("FAIL crlf_lf_dropped: lv=%b rdy=%b, want lv=0 rdy=1", line_valid, rx_data_ready);
      end
      send_byte(8'h58); send_byte(8'h0A);
      n_cmp++;
      if (line_valid !== 1'b1 || line_len !== 7'd1 || rd_data !== 8'h58 || rd_last !== 1'b1) begin
         n_err++;
         $display("FAIL crlf_second: lv=%b len=%0d d=%h l=%b, want lv=1 len=1 d=58 l=1",
                  line_valid, line_len, rd_data, rd_last);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
   endtask

   task automatic test_backspace();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h44); send_byte(8'h08);
      send_byte(8'h43); send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd3) begin
         n_err++; $display("FAIL bs_len: len=%0d want 3", line_len);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rd_data !== exp[i] || rd_last !== (i == 2)) begin
            n_err++;
            $display("FAIL bs_rd[%0d]: d=%h l=%b, want d=%h l=%b", i, rd_data, rd_last, exp[i], (i == 2));
         end
         rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      end
      // Backspace and DEL at an empty buffer, then a lone CR
      send_byte(8'h08); send_byte(8'h7F); send_byte(8'h0D);
      tick();
      n_cmp++;
      if (line_valid !== 1'b0 || rx_data_ready !== 1'b1) begin
         n_err++; $display("FAIL bs_empty_cr: lv=%b rdy=%b, want lv=0 rdy=1", line_valid, rx_data_ready);
      end
      send_byte(8'h51); send_byte(8'h52); send_byte(8'h7F); send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd1 || rd_data !== 8'h51 || rd_last !== 1'b1) begin
         n_err++; $display("FAIL bs_del: len=%0d d=%h l=%b, want len=1 d=51 l=1", line_len, rd_data, rd_last);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
   endtask

   task automatic test_overflow();
      int bad = 0;
      for (int i = 0; i < 70; i++) send_byte(8'(8'h30 + i));
      send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd64 || line_overflow !== 1'b1) begin
         n_err++; $display("FAIL ovf_line: len=%0d ovf=%b, want len=64 ovf=1", line_len, line_overflow);
      end
      for (int i = 0; i < 64; i++) begin
         if (rd_data !== 8'(8'h30 + i) || rd_last !== (i == 63)) begin
            if (bad == 0)
               $display("FAIL ovf_rd[%0d]: d=%h l=%b, want d=%h l=%b",
                        i, rd_data, rd_last, 8'(8'h30 + i), (i == 63));
            bad++;
         end
         rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      end
      n_cmp++;
      if (bad != 0) n_err++;
      n_cmp++;
      if (line_overflow !== 1'b0 || rx_data_ready !== 1'b1) begin
         n_err++; $display("FAIL ovf_clear: ovf=%b rdy=%b, want ovf=0 rdy=1", line_overflow, rx_data_ready);
      end
      send_byte(8'h4B); send_byte(8'h0D);
      n_cmp++;
      if (line_overflow !== 1'b0 || line_len !== 7'd1 || rd_data !== 8'h4B) begin
         n_err++;
         $display("FAIL ovf_next_line: ovf=%b len=%0d d=%h, want ovf=0 len=1 d=4b",
                  line_overflow, line_len, rd_data);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
   endtask

   task automatic test_stall();
      logic [7:0] exp [3] = '{8'h58, 8'h59, 8'h5A};
      int bad = 0;
      send_byte(8'h58); send_byte(8'h59); send_byte(8'h5A); send_byte(8'h0D);
      for (int c = 0; c < 20; c++) begin
         rx_data       = 8'(8'h61 + c);
         rx_data_valid = c[0];
         tick();
         if (rd_data !== 8'h58 || rd_valid !== 1'b1 || rd_last !== 1'b0 || rx_data_ready !== 1'b0) begin
            if (bad == 0)
               $display("FAIL stall_hold[%0d]: d=%h v=%b l=%b rdy=%b, want d=58 v=1 l=0 rdy=0",
                        c, rd_data, rd_valid, rd_last, rx_data_ready);
            bad++;
         end
      end
      rx_data_valid = 1'b0;
      n_cmp++;
      if (bad != 0) n_err++;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rd_data !== exp[i] || rd_last !== (i == 2)) begin
            n_err++;
            $display("FAIL stall_rd[%0d]: d=%h l=%b, want d=%h l=%b", i, rd_data, rd_last, exp[i], (i == 2));
         end
         rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      end
   endtask

   task automatic test_flush();
      send_byte(8'h41); send_byte(8'h42);
      flush = 1'b1; rx_data = 8'h51; rx_data_valid = 1'b1;
      tick();
      flush = 1'b0; rx_data_valid = 1'b0;
      send_byte(8'h5A); send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd1 || rd_data !== 8'h5A || rd_last !== 1'b1) begin
         n_err++; $display("FAIL flush_fill: len=%0d d=%h l=%b, want len=1 d=5a l=1", line_len, rd_data, rd_last);
      end
      // Flush wins over a simultaneous read handshake in DRAIN
      flush = 1'b1; rd_ready = 1'b1;
      tick();
      flush = 1'b0; rd_ready = 1'b0;
      n_cmp++;
      if ({line_valid, rd_valid, rd_last, line_len, rd_data, rx_data_ready}
          !== {1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b1}) begin
         n_err++;
         $display("FAIL flush_drain: lv=%b v=%b l=%b len=%0d d=%h rdy=%b, want 0 0 0 0 00 1",
                  line_valid, rd_valid, rd_last, line_len, rd_data, rx_data_ready);
      end
      send_byte(8'h50); send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd1 || rd_data !== 8'h50) begin
         n_err++; $display("FAIL flush_after: len=%0d d=%h, want len=1 d=50", line_len, rd_data);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      send_byte(8'h52); send_byte(8'h53); send_byte(8'h0D);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rx_data_ready, line_valid, line_len, line_overflow, rd_data, rd_valid, rd_last}
          !== {1'b1, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset: rdy=%b lv=%b len=%0d ovf=%b d=%h v=%b l=%b, want rdy=1 rest 0",
                  rx_data_ready, line_valid, line_len, line_overflow, rd_data, rd_valid, rd_last);
      end
      tick();
      rst_n = 1'b1;
      tick();
      send_byte(8'h54); send_byte(8'h0D);
      n_cmp++;
      if (line_len !== 7'd1 || rd_data !== 8'h54) begin
         n_err++; $display("FAIL reset_after: len=%0d d=%h, want len=1 d=54", line_len, rd_data);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_crlf();
      test_backspace();
      test_overflow();
      test_stall();
      test_flush();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
